// File: rtl/mc_controller_if.sv
// ============================================================================
// mc_controller_if : instruction fields, ALU flag and datapath control bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, funct, zero,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, pcen, alucontrol, state, instr_done, illegal
  );

  modport slave (
    output op, funct, zero,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, pcen, alucontrol, state, instr_done, illegal
  );
endinterface

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
// mc_controller : multicycle control FSM and ALU decoder for the 32-bit core
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_controller (
  input  logic             clk,
  input  logic             rst_n,
  mc_controller_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  state_t     state_q, state_d;
  logic [1:0] w_aluop;
  logic       w_pcwrite, w_branch;
  logic       w_iord, w_memwrite, w_irwrite, w_regdst, w_memtoreg;
  logic       w_regwrite, w_alusrca, w_done, w_bad_op, w_bad_funct;
  logic [1:0] w_alusrcb, w_pcsrc;
  logic [2:0] w_alucontrol;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    w_aluop    = 2'b00;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    w_done     = 1'b0;
    w_bad_op   = 1'b0;
    case (state_q)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_alusrcb = 2'b01;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        case (bus.op)
          C_OP_LW, C_OP_SW: state_d = S_MEMADR;
          C_OP_RTYPE:       state_d = S_RTYPEEX;
          C_OP_BEQ:         state_d = S_BEQEX;
          C_OP_ADDI:        state_d = S_ADDIEX;
          C_OP_J:           state_d = S_JEX;
          default: begin
            // Unsupported op retires immediately so the core keeps fetching
            state_d  = S_FETCH;
            w_bad_op = 1'b1;
            w_done   = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        state_d   = (bus.op == C_OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_iord  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_RTYPEEX: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        state_d   = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_BEQEX: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
        w_done    = 1'b1;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_JEX: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_done    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // aluop=10 only occurs in RTYPEEX, so a bad funct flags illegal there alone
  always_comb begin
    w_alucontrol = 3'b010;
    w_bad_funct  = 1'b0;
    case (w_aluop)
      2'b01: w_alucontrol = 3'b110;
      2'b10: begin
        case (bus.funct)
          6'b100000: w_alucontrol = 3'b010;
          6'b100010: w_alucontrol = 3'b110;
          6'b100100: w_alucontrol = 3'b000;
          6'b100101: w_alucontrol = 3'b001;
          6'b101010: w_alucontrol = 3'b111;
          default:   w_bad_funct  = 1'b1;
        endcase
      end
      default: w_alucontrol = 3'b010;
    endcase
  end

  assign bus.iord       = rst_n & w_iord;
  assign bus.memwrite   = rst_n & w_memwrite;
  assign bus.irwrite    = rst_n & w_irwrite;
  assign bus.regdst     = rst_n & w_regdst;
  assign bus.memtoreg   = rst_n & w_memtoreg;
  assign bus.regwrite   = rst_n & w_regwrite;
  assign bus.alusrca    = rst_n & w_alusrca;
  assign bus.alusrcb    = rst_n ? w_alusrcb : 2'b00;
  assign bus.pcsrc      = rst_n ? w_pcsrc : 2'b00;
  assign bus.pcen       = rst_n & (w_pcwrite | (w_branch & bus.zero));
  assign bus.alucontrol = rst_n ? w_alucontrol : 3'b000;
  assign bus.state      = rst_n ? state_q : 4'd0;
  assign bus.instr_done = rst_n & w_done;
  assign bus.illegal    = rst_n & (w_bad_op | w_bad_funct);

endmodule

`default_nettype wire
